tick_sched: RTL

//  Runtime-programmable clock-enable scheduler. It replaces fixed counter-bit clocks with NCH

---
 rtl/tick_sched_if.sv | 39 +++
 rtl/tick_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/tick_sched_if.sv
// ---------------------------------------------------------------------------
// tick_sched_if
// Configuration port of the tick scheduler: a valid/ready request that loads
// a new divide ratio and enable for one channel.
//
//   cfg_valid  master -> slave  request valid
//   cfg_ready  slave  -> master port can accept a request this cycle
//   cfg_ch     master -> slave  target channel (CHW bits)
//   cfg_div    master -> slave  new period in clk cycles, 0 disables
//   cfg_en     master -> slave  1 enable the channel, 0 disable it
// ---------------------------------------------------------------------------
interface tick_sched_if #(
  parameter int NCH = 4,
  parameter int CW  = 17
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           cfg_en;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    output cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_en,
    output cfg_ready
  );
endinterface

// File: rtl/tick_sched.sv
// ---------------------------------------------------------------------------
// tick_sched
// Runtime-programmable clock-enable scheduler. Each of NCH channels produces
// a single-cycle strobe once every div[i] clk cycles; downstream logic uses
// o_tick[i] as a clock enable on the master clock. New divide ratios arrive
// over the cfg interface and are held pending until the target channel wraps
// (or is idle, or a sync strobe arrives), so a running channel never emits a
// shortened or stretched period. i_sync restarts the phase of every active
// channel.
//
// Ports
//   clk       in   master clock, everything on posedge
//   rst       in   synchronous active-low reset
//   cfg       if   configuration request port (slave side)
//   i_sync    in   one-cycle strobe, restarts phase of all active channels
//   o_tick    out  per-channel one-cycle enable strobes (decoded from flops)
//   o_active  out  per-channel applied enable state
// ---------------------------------------------------------------------------
module tick_sched #(
  parameter int NCH = 4,
  parameter int CW  = 17
) (
  input  logic           clk,
  input  logic           rst,
  tick_sched_if.slave    cfg,
  input  logic           i_sync,
  output logic [NCH-1:0] o_tick,
  output logic [NCH-1:0] o_active
);

  localparam int            CHW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LP_ONE = CW'(1);

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } state_t;

  // Per-channel applied configuration and phase counter.
  logic [CW-1:0]  r_cnt [NCH];
  logic [CW-1:0]  r_div [NCH];
  logic [NCH-1:0] r_active;

  // Single pending request slot.
  state_t         r_state;
  state_t         w_state_nxt;
  logic [CHW-1:0] r_p_ch;
  logic [CW-1:0]  r_p_div;
  logic           r_p_en;

  logic [NCH-1:0] w_tick;
  logic           w_ch_ok;
  logic           w_eff_en;
  logic           w_accept;
  logic           w_apply;

  // Tick is decoded purely from registered state, so there is no
  // combinational path from any input to o_tick.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_tick[i] = r_active[i] && (r_cnt[i] == (r_div[i] - LP_ONE));
    end
  end

  // Channel-index range check. When NCH fills the index field every code is
  // legal, and the compare would be constant, so it is elided.
  if (NCH == (2 ** CHW)) begin : g_ch_full
    assign w_ch_ok = 1'b1;
  end else begin : g_ch_part
    assign w_ch_ok = (cfg.cfg_ch < CHW'(NCH));
  end

  // A zero divisor can never be applied: it turns the request into a disable.
  assign w_eff_en = cfg.cfg_en && (cfg.cfg_div != '0);

  // Config FSM, next-state and outputs.
  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_apply       = 1'b0;
    cfg.cfg_ready = (r_state == ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        // Requests to a non-existent channel are consumed and dropped.
        if (cfg.cfg_valid && w_ch_ok) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        // Apply only at a wrap point of the target: idle channel, its final
        // tick of the old period, or a global phase restart.
        if (!r_active[r_p_ch] || w_tick[r_p_ch] || i_sync) begin
          w_apply     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the pending payload has no reset; it is only ever read while the
  // FSM is in ST_PEND, and reset forces the FSM back to ST_IDLE.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_p_ch  <= cfg.cfg_ch;
      r_p_en  <= w_eff_en;
      r_p_div <= w_eff_en ? cfg.cfg_div : LP_ONE;
    end
  end

  // Channel counters. The tick cycle itself is the last cycle of the old
  // configuration; the counter restarts at zero on the apply edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (!rst) begin
        r_cnt[i]    <= '0;
        r_div[i]    <= LP_ONE;
        r_active[i] <= 1'b0;
      end else if (w_apply && (r_p_ch == CHW'(i))) begin
        r_cnt[i]    <= '0;
        r_div[i]    <= r_p_div;
        r_active[i] <= r_p_en;
      end else if (!r_active[i] || i_sync || w_tick[i]) begin
        r_cnt[i]    <= '0;
      end else begin
        r_cnt[i]    <= r_cnt[i] + LP_ONE;
      end
    end
  end

  assign o_tick   = w_tick;
  assign o_active = r_active;

endmodule
